// File: rtl/store_port_arbiter_if.sv
// Store-port bundle: per-requester requests/payloads in, muxed cache write port out.
interface store_port_arbiter_if #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned PLEN     = 56,
    parameter int unsigned XLEN     = 64
);
    logic [NR_PORTS-1:0]                 req;
    logic [NR_PORTS-1:0]                 lock;
    logic [NR_PORTS-1:0][PLEN-1:0]       addr;
    logic [NR_PORTS-1:0][XLEN-1:0]       data;
    logic [NR_PORTS-1:0][XLEN/8-1:0]     be;
    logic [NR_PORTS-1:0][1:0]            size;
    logic [NR_PORTS-1:0]                 gnt;

    logic                                data_req;
    logic                                data_gnt;
    logic [PLEN-1:0]                     cache_addr;
    logic [XLEN-1:0]                     cache_data;
    logic [XLEN/8-1:0]                   cache_be;
    logic [1:0]                          cache_size;
    logic                                busy;

    modport slave (
        input  req, lock, addr, data, be, size, data_gnt,
        output gnt, data_req, cache_addr, cache_data, cache_be, cache_size, busy
    );

    modport master (
        output req, lock, addr, data, be, size, data_gnt,
        input  gnt, data_req, cache_addr, cache_data, cache_be, cache_size, busy
    );
endinterface

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter sharing the data-cache store port; holds its pick until the
// cache grants, with an optional per-requester lock that keeps priority on the winner.
module store_port_arbiter #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned PLEN     = 56,
    parameter int unsigned XLEN     = 64
) (
    input logic               clk_i,
    input logic               rst_ni,
    store_port_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    typedef enum logic [0:0] {StIdle, StWaitGnt} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [IDX_W-1:0]       winner, cand, mux_idx;
    logic                   found;
    logic [NR_PORTS-1:0]    gnt;
    int unsigned            idx;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w, input logic lck);
        if (lck) return w;
        if (w == IDX_W'(NR_PORTS - 1)) return '0;
        return w + IDX_W'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NR_PORTS.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            cand = IDX_W'(idx);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        gnt          = '0;
        bus.data_req = 1'b0;
        bus.busy     = 1'b0;
        mux_idx      = winner;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    bus.data_req = 1'b1;
                    if (bus.data_gnt) begin
                        gnt[winner] = 1'b1;
                        rr_ptr_d    = next_ptr(winner, bus.lock[winner]);
                    end else begin
                        sel_d   = winner;
                        state_d = StWaitGnt;
                    end
                end
            end
            StWaitGnt: begin
                bus.busy     = 1'b1;
                mux_idx      = sel_q;
                bus.data_req = bus.req[sel_q];
                // A requester withdrawing mid-wait is a protocol error; abandon without grant.
                if (!bus.req[sel_q]) begin
                    state_d = StIdle;
                end else if (bus.data_gnt) begin
                    gnt[sel_q] = 1'b1;
                    rr_ptr_d   = next_ptr(sel_q, bus.lock[sel_q]);
                    state_d    = StIdle;
                end
            end
        endcase
    end

    assign bus.gnt        = gnt;
    assign bus.cache_addr = bus.addr[mux_idx];
    assign bus.cache_data = bus.data[mux_idx];
    assign bus.cache_be   = bus.be[mux_idx];
    assign bus.cache_size = bus.size[mux_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
        end
    end

    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.data_gnt |-> bus.data_req);

    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StWaitGnt) |-> bus.req[sel_q]);

    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StWaitGnt) |-> ($stable(bus.addr[sel_q]) && $stable(bus.data[sel_q]) &&
                                    $stable(bus.be[sel_q]) && $stable(bus.size[sel_q])));
endmodule

// File: tb/tb_store_port_arbiter.sv
// Bench for store_port_arbiter: 2-port and 3-port instances, grants scored from a queue.
module tb_store_port_arbiter;
    localparam int unsigned PLEN = 32;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    store_port_arbiter_if #(.NR_PORTS(2), .PLEN(PLEN), .XLEN(XLEN)) ifa ();
    store_port_arbiter_if #(.NR_PORTS(3), .PLEN(PLEN), .XLEN(XLEN)) ifb ();

    store_port_arbiter #(.NR_PORTS(2), .PLEN(PLEN), .XLEN(XLEN)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_a),
        .bus   (ifa)
    );

    store_port_arbiter #(.NR_PORTS(3), .PLEN(PLEN), .XLEN(XLEN)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_b),
        .bus   (ifb)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  gnt;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t sb_a[$];
    sb_t sb_b[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'h8000_1000 + 32'(p) * 32'h1000;
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return 32'hD000_0000 + 32'(p);
    endfunction

    task automatic exp_a(input string tag, input logic [3:0] g, input int p);
        sb_t e;
        e.tag = tag; e.gnt = g; e.addr = addr_of(p); e.data = data_of(p);
        sb_a.push_back(e);
    endtask

    task automatic exp_b(input string tag, input logic [3:0] g, input int p);
        sb_t e;
        e.tag = tag; e.gnt = g; e.addr = addr_of(p); e.data = data_of(p);
        sb_b.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted cache transaction must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rst_a && ifa.data_req && ifa.data_gnt) begin
            if (sb_a.size() == 0) check_eq("a_unexpected_grant", 64'(sb_a.size()), 64'd1);
            else begin
                e = sb_a.pop_front();
                check_eq({e.tag, "_gnt"}, 64'(ifa.gnt), 64'(e.gnt));
                check_eq({e.tag, "_addr"}, 64'(ifa.cache_addr), 64'(e.addr));
                check_eq({e.tag, "_data"}, 64'(ifa.cache_data), 64'(e.data));
            end
        end
        if (rst_b && ifb.data_req && ifb.data_gnt) begin
            if (sb_b.size() == 0) check_eq("b_unexpected_grant", 64'(sb_b.size()), 64'd1);
            else begin
                e = sb_b.pop_front();
                check_eq({e.tag, "_gnt"}, 64'(ifb.gnt), 64'(e.gnt));
                check_eq({e.tag, "_addr"}, 64'(ifb.cache_addr), 64'(e.addr));
                check_eq({e.tag, "_data"}, 64'(ifb.cache_data), 64'(e.data));
            end
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.req = '0; ifa.lock = '0; ifa.data_gnt = 1'b0; ifa.be = '1; ifa.size = '0;
        ifb.req = '0; ifb.lock = '0; ifb.data_gnt = 1'b0; ifb.be = '1; ifb.size = '0;
        for (int p = 0; p < 2; p++) begin
            ifa.addr[p] = addr_of(p);
            ifa.data[p] = data_of(p);
        end
        for (int p = 0; p < 3; p++) begin
            ifb.addr[p] = addr_of(p);
            ifb.data[p] = data_of(p);
        end

        repeat (2) tick();
        @(negedge clk);
        check_eq("rst_data_req", 64'(ifa.data_req), 64'd0);
        check_eq("rst_gnt", 64'(ifa.gnt), 64'd0);
        check_eq("rst_busy", 64'(ifa.busy), 64'd0);
        check_eq("rst_b_busy", 64'(ifb.busy), 64'd0);

        // Release reset with port0 already requesting; cache grants in the first cycle.
        ifa.req = 2'b01;
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.data_gnt = 1'b1;
        exp_a("first", 4'b01, 0);
        @(negedge clk);
        check_eq("first_data_req", 64'(ifa.data_req), 64'd1);
        tick();

        // Round robin starting at port1.
        ifa.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_a("rr", 4'b10, 1);
            else            exp_a("rr", 4'b01, 0);
            tick();
        end

        // Cache stalls three cycles; port1 arrives while waiting and must be ignored.
        ifa.req = 2'b01;
        ifa.data_gnt = 1'b0;
        @(negedge clk);
        check_eq("w0_data_req", 64'(ifa.data_req), 64'd1);
        check_eq("w0_gnt", 64'(ifa.gnt), 64'd0);
        check_eq("w0_busy", 64'(ifa.busy), 64'd0);
        check_eq("w0_addr", 64'(ifa.cache_addr), 64'(addr_of(0)));
        tick();
        ifa.req = 2'b11;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            check_eq("wait_busy", 64'(ifa.busy), 64'd1);
            check_eq("wait_gnt", 64'(ifa.gnt), 64'd0);
            check_eq("wait_addr", 64'(ifa.cache_addr), 64'(addr_of(0)));
            tick();
        end
        ifa.data_gnt = 1'b1;
        exp_a("w3", 4'b01, 0);
        @(negedge clk);
        check_eq("w3_busy", 64'(ifa.busy), 64'd1);
        tick();
        ifa.req = 2'b10;
        exp_a("w4", 4'b10, 1);
        @(negedge clk);
        check_eq("w4_busy", 64'(ifa.busy), 64'd0);
        tick();

        // Lock on port1 keeps priority there for back-to-back grants.
        ifa.req = 2'b01;
        exp_a("lk_pre", 4'b01, 0);
        tick();
        ifa.req  = 2'b11;
        ifa.lock = 2'b10;
        exp_a("lk1", 4'b10, 1);
        tick();
        exp_a("lk2", 4'b10, 1);
        tick();
        ifa.lock = 2'b00;
        exp_a("unlk1", 4'b10, 1);
        tick();
        exp_a("unlk2", 4'b01, 0);
        tick();
        ifa.req = '0;
        ifa.data_gnt = 1'b0;
        tick();

        // Three ports: rotation wraps 2 -> 0.
        ifb.req = 3'b111;
        ifb.data_gnt = 1'b1;
        exp_b("b_rr0", 4'b001, 0);
        tick();
        exp_b("b_rr1", 4'b010, 1);
        tick();
        exp_b("b_rr2", 4'b100, 2);
        tick();
        exp_b("b_rr3", 4'b001, 0);
        tick();
        ifb.data_gnt = 1'b0;
        @(negedge clk);
        check_eq("b_stall_gnt", 64'(ifb.gnt), 64'd0);
        check_eq("b_stall_addr", 64'(ifb.cache_addr), 64'(addr_of(1)));
        tick();
        @(negedge clk);
        check_eq("b_wait_busy", 64'(ifb.busy), 64'd1);
        rst_b = 1'b0;
        #1;
        check_eq("b_rst_busy", 64'(ifb.busy), 64'd0);
        check_eq("b_rst_gnt", 64'(ifb.gnt), 64'd0);
        tick();
        rst_b = 1'b1;
        ifb.data_gnt = 1'b1;
        exp_b("b_after_rst", 4'b001, 0);
        tick();
        ifb.req = '0;
        ifb.data_gnt = 1'b0;
        repeat (2) tick();

        check_eq("a_sb_drained", 64'(sb_a.size()), 64'd0);
        check_eq("b_sb_drained", 64'(sb_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
